// File: rtl/max_idx_feeder.sv
// rtl/max_idx_feeder.sv - collects ten scores, runs the argmax unit, returns the class index and accuracy counts
module max_idx_feeder #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] in_data,
    input  logic [3:0]              in_label,
    output logic [10*WIDTH-1:0]     am_inputs,
    output logic                    am_start,
    input  logic [3:0]              am_idx,
    input  logic                    am_done,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [3:0]              res_idx,
    output logic                    res_correct,
    output logic [CNT_W-1:0]        correct_count,
    output logic [CNT_W-1:0]        total_count
);

    typedef enum logic [1:0] {
        S_COLLECT,
        S_START,
        S_WAIT,
        S_RESULT
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              beat_cnt_q, beat_cnt_d;
    logic [3:0]              label_q, label_d;
    logic [3:0]              res_idx_q, res_idx_d;
    logic                    res_correct_q, res_correct_d;
    logic [CNT_W-1:0]        correct_q, correct_d;
    logic [CNT_W-1:0]        total_q, total_d;
    logic                    score_we;
    logic signed [WIDTH-1:0] score_q [10];

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Next-state and handshake outputs; the buffer is only written while collecting
    always_comb begin
        state_d       = state_q;
        beat_cnt_d    = beat_cnt_q;
        label_d       = label_q;
        res_idx_d     = res_idx_q;
        res_correct_d = res_correct_q;
        correct_d     = correct_q;
        total_d       = total_q;
        in_ready      = 1'b0;
        am_start      = 1'b0;
        res_valid     = 1'b0;
        score_we      = 1'b0;
        case (state_q)
            S_COLLECT: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    score_we = 1'b1;
                    if (beat_cnt_q == 4'd9) begin
                        beat_cnt_d = 4'd0;
                        label_d    = in_label;
                        state_d    = S_START;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 4'd1;
                    end
                end
            end
            S_START: begin
                am_start = 1'b1;
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                // done is only trusted here, after the start edge has cleared any stale level
                if (am_done) begin
                    res_idx_d     = am_idx;
                    res_correct_d = (am_idx == label_q) && (label_q <= 4'd9);
                    state_d       = S_RESULT;
                end
            end
            S_RESULT: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    if (total_q != CNT_MAX) begin
                        total_d = total_q + CNT_W'(1);
                    end
                    if (res_correct_q && (correct_q != CNT_MAX)) begin
                        correct_d = correct_q + CNT_W'(1);
                    end
                    state_d = S_COLLECT;
                end
            end
            default: state_d = S_COLLECT;
        endcase
    end

    // Control state register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_COLLECT;
            beat_cnt_q    <= 4'd0;
            label_q       <= 4'd0;
            res_idx_q     <= 4'd0;
            res_correct_q <= 1'b0;
            correct_q     <= '0;
            total_q       <= '0;
        end else begin
            state_q       <= state_d;
            beat_cnt_q    <= beat_cnt_d;
            label_q       <= label_d;
            res_idx_q     <= res_idx_d;
            res_correct_q <= res_correct_d;
            correct_q     <= correct_d;
            total_q       <= total_d;
        end
    end

    // Score buffer, entry k holds beat k; deliberately not reset
    always_ff @(posedge clk) begin
        if (score_we) begin
            for (int k = 0; k < 10; k++) begin
                if (beat_cnt_q == 4'(k)) begin
                    score_q[k] <= in_data;
                end
            end
        end
    end

    // Flatten the buffer onto the argmax input bus
    always_comb begin
        am_inputs = '0;
        for (int k = 0; k < 10; k++) begin
            am_inputs[k*WIDTH +: WIDTH] = score_q[k];
        end
    end

    assign res_idx       = res_idx_q;
    assign res_correct   = res_correct_q;
    assign correct_count = correct_q;
    assign total_count   = total_q;

endmodule

// File: tb/tb_max_idx_feeder.sv
// tb/tb_max_idx_feeder.sv - directed bench for max_idx_feeder with a 4-cycle argmax model
module tb_max_idx_feeder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset = 1'b1;
    logic              in_valid = 1'b0;
    logic              res_ready = 1'b1;
    logic signed [7:0] in_data = '0;
    logic [3:0]        in_label = '0;
    logic [3:0]        am_idx = '0;
    logic              am_done = 1'b0;

    logic        in_ready, am_start, res_valid, res_correct;
    logic [79:0] am_inputs;
    logic [3:0]  res_idx;
    logic [15:0] correct_count, total_count;

    logic        b_in_ready, b_am_start, b_res_valid, b_res_correct;
    logic [79:0] b_am_inputs;
    logic [3:0]  b_res_idx;
    logic [1:0]  b_correct_count, b_total_count;

    max_idx_feeder #(.WIDTH(8), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_label(in_label), .am_inputs(am_inputs),
        .am_start(am_start), .am_idx(am_idx), .am_done(am_done),
        .res_valid(res_valid), .res_ready(res_ready), .res_idx(res_idx),
        .res_correct(res_correct), .correct_count(correct_count),
        .total_count(total_count)
    );

    max_idx_feeder #(.WIDTH(8), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_data(in_data), .in_label(in_label), .am_inputs(b_am_inputs),
        .am_start(b_am_start), .am_idx(am_idx), .am_done(am_done),
        .res_valid(b_res_valid), .res_ready(res_ready), .res_idx(b_res_idx),
        .res_correct(b_res_correct), .correct_count(b_correct_count),
        .total_count(b_total_count)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int start_cnt = 0;
    logic signed [7:0] sc [10];
    logic [3:0] lbl;

    logic       busy = 1'b0;
    int         mcnt = 0;
    logic [3:0] m_idx = '0;

    function automatic logic [3:0] ref_argmax(input logic [79:0] v);
        int best = 0;
        for (int k = 1; k < 10; k++) begin
            if ($signed(v[k*8 +: 8]) > $signed(v[best*8 +: 8])) best = k;
        end
        return 4'(best);
    endfunction

    // argmax unit: done cleared on start, raised 3 edges later, left high while idle
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (am_start) begin
            busy    <= 1'b1;
            mcnt    <= 3;
            am_done <= 1'b0;
            m_idx   <= ref_argmax(am_inputs);
        end else if (busy) begin
            if (mcnt == 1) begin
                am_done <= 1'b1;
                am_idx  <= m_idx;
                busy    <= 1'b0;
            end else begin
                mcnt <= mcnt - 1;
            end
        end
    end

    always @(negedge clk) begin
        if (am_start === 1'b1) start_cnt = start_cnt + 1;
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; in_valid = 1'b0; res_ready = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic load_a();
        sc = '{-8'sd5, 8'sd3, 8'sd7, 8'sh80, 8'sd7, 8'sd0, 8'sd1, 8'sd2, 8'sd127, -8'sd1};
    endtask

    task automatic load_b();
        sc = '{8'sd0, 8'sd0, 8'sd0, 8'sd50, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0};
    endtask

    task automatic send_frame(input bit bubbly);
        int i = 0;
        int g = 0;
        bit gap = 1'b0;
        while (i < 10 && g < 100) begin
            @(negedge clk);
            g++;
            if (bubbly && gap) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1; in_data = sc[i]; in_label = lbl;
            end
            gap = !gap;
            if (in_valid && in_ready) begin
                if (i == 9) acc_cyc = cyc;
                i++;
            end
        end
        total++;
        if (i !== 10) begin bad++; $display("FAIL send_frame beats=%0d want 10", i); end
    endtask

    task automatic wait_res(output int lat);
        int g = 0;
        @(negedge clk);
        in_valid = 1'b0;
        while (res_valid !== 1'b1 && g < 60) begin
            @(negedge clk);
            g++;
        end
        lat = cyc - acc_cyc;
        total++;
        if (res_valid !== 1'b1) begin bad++; $display("FAIL wait_res timeout res_valid=%b want 1", res_valid); end
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; res_ready = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({in_ready, am_start, res_valid, res_idx, res_correct} !== 8'b1000_0000) begin
            bad++; $display("FAIL reset_outputs got=%b want 10000000", {in_ready, am_start, res_valid, res_idx, res_correct});
        end
        total++;
        if ({correct_count, total_count} !== 32'd0) begin
            bad++; $display("FAIL reset_counts got=%h want 0", {correct_count, total_count});
        end
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want 1", in_ready); end
    endtask

    task automatic test_single_frame();
        int lat;
        int s0;
        do_reset();
        load_a(); lbl = 4'd8; s0 = start_cnt;
        send_frame(1'b0);
        wait_res(lat);
        total++; if (lat !== 6) begin bad++; $display("FAIL single_latency got=%0d want 6", lat); end
        total++; if (res_idx !== 4'd8) begin bad++; $display("FAIL single_idx got=%0d want 8", res_idx); end
        total++; if (res_correct !== 1'b1) begin bad++; $display("FAIL single_correct got=%b want 1", res_correct); end
        @(negedge clk);
        total++; if (start_cnt - s0 !== 1) begin bad++; $display("FAIL single_start_pulses got=%0d want 1", start_cnt - s0); end
        total++; if (correct_count !== 16'd1 || total_count !== 16'd1) begin
            bad++; $display("FAIL single_counts got=%0d/%0d want 1/1", correct_count, total_count);
        end
        total++; if (in_ready !== 1'b1 || res_valid !== 1'b0) begin
            bad++; $display("FAIL single_return got ready=%b valid=%b want 1 0", in_ready, res_valid);
        end
    endtask

    task automatic test_backpressure();
        int lat;
        do_reset();
        load_b(); lbl = 4'd2; res_ready = 1'b0;
        send_frame(1'b0);
        wait_res(lat);
        total++; if (res_correct !== 1'b0) begin bad++; $display("FAIL bp_correct got=%b want 0", res_correct); end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            total++;
            if ({res_valid, res_idx, in_ready} !== 6'b1_0011_0) begin
                bad++; $display("FAIL bp_hold cyc=%0d got valid=%b idx=%0d ready=%b want 1 3 0", c, res_valid, res_idx, in_ready);
            end
        end
        res_ready = 1'b1;
        @(negedge clk);
        total++; if (total_count !== 16'd1 || correct_count !== 16'd0) begin
            bad++; $display("FAIL bp_counts got=%0d/%0d want 0/1", correct_count, total_count);
        end
        total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL bp_release got=%b want 0", res_valid); end
    endtask

    task automatic test_bubbly();
        int lat;
        int s0;
        logic [79:0] exp;
        do_reset();
        sc = '{8'sd10, -8'sd20, 8'sd30, -8'sd40, 8'sd50, -8'sd60, 8'sd70, -8'sd80, 8'sd90, -8'sd100};
        lbl = 4'd8; s0 = start_cnt;
        for (int k = 0; k < 10; k++) exp[k*8 +: 8] = sc[k];
        send_frame(1'b1);
        total++; if (start_cnt !== s0) begin bad++; $display("FAIL bubbly_early_start got=%0d want %0d", start_cnt, s0); end
        wait_res(lat);
        total++; if (am_inputs !== exp) begin bad++; $display("FAIL bubbly_buffer got=%h want %h", am_inputs, exp); end
        total++; if (start_cnt - s0 !== 1) begin bad++; $display("FAIL bubbly_start_pulses got=%0d want 1", start_cnt - s0); end
        total++; if (res_idx !== 4'd8) begin bad++; $display("FAIL bubbly_idx got=%0d want 8", res_idx); end
        @(negedge clk);
    endtask

    task automatic test_stale_done();
        int lat;
        do_reset();
        load_a(); lbl = 4'd8;
        send_frame(1'b0);
        wait_res(lat);
        @(negedge clk);
        sc = '{8'sd0, 8'sd100, -8'sd3, 8'sd99, 8'sd5, 8'sd5, 8'sd5, 8'sd5, 8'sd5, 8'sd5};
        lbl = 4'd1;
        send_frame(1'b0);
        wait_res(lat);
        total++; if (lat !== 6) begin bad++; $display("FAIL stale_latency got=%0d want 6", lat); end
        total++; if (res_idx !== 4'd1) begin bad++; $display("FAIL stale_idx got=%0d want 1", res_idx); end
        @(negedge clk);
        total++; if (correct_count !== 16'd2 || total_count !== 16'd2) begin
            bad++; $display("FAIL stale_counts got=%0d/%0d want 2/2", correct_count, total_count);
        end
    endtask

    task automatic test_reset_midop();
        int lat;
        do_reset();
        load_a(); lbl = 4'd8;
        for (int b = 0; b < 5; b++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = sc[b]; in_label = lbl;
        end
        @(negedge clk);
        in_data = sc[5]; reset = 1'b1;
        @(negedge clk);
        total++;
        if ({in_ready, am_start, res_valid, res_idx, res_correct} !== 8'b1000_0000) begin
            bad++; $display("FAIL midcollect_reset got=%b want 10000000", {in_ready, am_start, res_valid, res_idx, res_correct});
        end
        reset = 1'b0; in_valid = 1'b0;
        send_frame(1'b0);
        wait_res(lat);
        total++; if (res_idx !== 4'd8 || res_correct !== 1'b1) begin
            bad++; $display("FAIL midcollect_frame got idx=%0d ok=%b want 8 1", res_idx, res_correct);
        end
        @(negedge clk);
        send_frame(1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        total++; if (in_ready !== 1'b0 || am_start !== 1'b0 || res_valid !== 1'b0) begin
            bad++; $display("FAIL wait_state got ready=%b start=%b valid=%b want 0 0 0", in_ready, am_start, res_valid);
        end
        reset = 1'b1;
        @(negedge clk);
        total++;
        if ({in_ready, am_start, res_valid, res_idx, res_correct} !== 8'b1000_0000) begin
            bad++; $display("FAIL midwait_reset got=%b want 10000000", {in_ready, am_start, res_valid, res_idx, res_correct});
        end
        total++; if ({correct_count, total_count} !== 32'd0) begin
            bad++; $display("FAIL midwait_counts got=%h want 0", {correct_count, total_count});
        end
        reset = 1'b0;
        load_b(); lbl = 4'd3;
        send_frame(1'b0);
        wait_res(lat);
        total++; if (lat !== 6 || res_idx !== 4'd3 || res_correct !== 1'b1) begin
            bad++; $display("FAIL after_reset_frame got lat=%0d idx=%0d ok=%b want 6 3 1", lat, res_idx, res_correct);
        end
        @(negedge clk);
        total++; if (correct_count !== 16'd1 || total_count !== 16'd1) begin
            bad++; $display("FAIL after_reset_counts got=%0d/%0d want 1/1", correct_count, total_count);
        end
    endtask

    task automatic test_saturation();
        int lat;
        do_reset();
        load_a(); lbl = 4'd8;
        for (int f = 0; f < 5; f++) begin
            send_frame(1'b0);
            wait_res(lat);
            @(negedge clk);
        end
        total++; if (b_correct_count !== 2'd3 || b_total_count !== 2'd3) begin
            bad++; $display("FAIL sat_counts got=%0d/%0d want 3/3", b_correct_count, b_total_count);
        end
        total++; if (correct_count !== 16'd5 || total_count !== 16'd5) begin
            bad++; $display("FAIL wide_counts got=%0d/%0d want 5/5", correct_count, total_count);
        end
        lbl = 4'd12;
        send_frame(1'b0);
        wait_res(lat);
        total++; if (res_correct !== 1'b0 || b_res_correct !== 1'b0 || b_res_idx !== 4'd8) begin
            bad++; $display("FAIL label12 got ok=%b bok=%b bidx=%0d want 0 0 8", res_correct, b_res_correct, b_res_idx);
        end
        @(negedge clk);
        total++; if (b_correct_count !== 2'd3 || b_total_count !== 2'd3 || b_in_ready !== 1'b1 || b_res_valid !== 1'b0) begin
            bad++; $display("FAIL sat_hold got=%0d/%0d ready=%b valid=%b want 3/3 1 0", b_correct_count, b_total_count, b_in_ready, b_res_valid);
        end
        total++; if (correct_count !== 16'd5 || total_count !== 16'd6) begin
            bad++; $display("FAIL label12_counts got=%0d/%0d want 5/6", correct_count, total_count);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_backpressure();
        test_bubbly();
        test_stale_done();
        test_reset_midop();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
